bus_host_arbiter: RTL and testbench

//  Round-robin arbiter sharing one simple-system device-bus port between NrHosts hosts,
//  e.g. core data port plus a DMA/debug host. Hosts and device use req/gnt/rvalid protocol.

---
 rtl/bus_host_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_bus_host_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_host_arbiter.sv
// Generic FIFO with head peek and occupancy count.
// Latency: a pushed entry appears at the head the cycle after the push; a pop retires the head at the next edge.
// Backpressure: none internally; the caller never pushes when full_o or pops when empty_o.
module bus_host_arbiter_fifo #(
    parameter int Width = 1,
    parameter int Depth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [Width-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [Width-1:0]             rdata_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign rdata_o = mem[rd_ptr_q];
    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == ($clog2(Depth+1))'(Depth));

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_o  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end
endmodule

// Round-robin arbiter sharing one req/gnt/rvalid device port among NrHosts hosts.
// Latency: zero-cycle request and response paths; in-order responses routed via an ID FIFO.
// Backpressure: a stalled request is locked to its host until granted; no request while MaxOutstanding are open.
module bus_host_arbiter #(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NrHosts-1:0]                    host_req_i,
    output logic [NrHosts-1:0]                    host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]       host_addr_i,
    input  logic [NrHosts-1:0]                    host_we_i,
    input  logic [NrHosts*4-1:0]                  host_be_i,
    input  logic [NrHosts*DataWidth-1:0]          host_wdata_i,
    output logic [NrHosts-1:0]                    host_rvalid_o,
    output logic [DataWidth-1:0]                  host_rdata_o,
    output logic                                  host_err_o,
    output logic                                  dev_req_o,
    input  logic                                  dev_gnt_i,
    output logic [AddressWidth-1:0]               dev_addr_o,
    output logic                                  dev_we_o,
    output logic [3:0]                            dev_be_o,
    output logic [DataWidth-1:0]                  dev_wdata_o,
    input  logic                                  dev_rvalid_i,
    input  logic [DataWidth-1:0]                  dev_rdata_i,
    input  logic                                  dev_err_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
    output logic                                  spurious_rsp_o
);
    localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;

    logic [AddressWidth-1:0] addr_arr  [NrHosts];
    logic [3:0]              be_arr    [NrHosts];
    logic [DataWidth-1:0]    wdata_arr [NrHosts];

    logic [IdxW-1:0] rr_ptr_q;
    logic [IdxW-1:0] lock_idx_q;
    logic            lock_vld_q;
    logic            lock_hold;
    logic [IdxW-1:0] winner;
    logic [IdxW-1:0] head_idx;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;

    for (genvar g = 0; g < NrHosts; g++) begin : g_unpack
        assign addr_arr[g]  = host_addr_i[g*AddressWidth +: AddressWidth];
        assign be_arr[g]    = host_be_i[g*4 +: 4];
        assign wdata_arr[g] = host_wdata_i[g*DataWidth +: DataWidth];
    end

    // A lock only counts while its host keeps requesting; a dropped request reopens arbitration.
    assign lock_hold = lock_vld_q & host_req_i[lock_idx_q];

    // Scan downwards so the last hit is the nearest requester at or after the pointer.
    always_comb begin
        int cand;
        cand   = 0;
        winner = lock_idx_q;
        if (!lock_hold) begin
            winner = rr_ptr_q;
            for (int i = NrHosts - 1; i >= 0; i--) begin
                cand = int'(rr_ptr_q) + i;
                if (cand >= NrHosts) cand = cand - NrHosts;
                if (host_req_i[IdxW'(cand)]) winner = IdxW'(cand);
            end
        end
    end

    assign dev_req_o = (|host_req_i) & ~fifo_full & ~rst_i;
    assign push      = dev_req_o & dev_gnt_i;
    assign pop       = dev_rvalid_i & ~fifo_empty;

    always_comb begin
        dev_addr_o  = '0;
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        dev_wdata_o = '0;
        if (dev_req_o) begin
            dev_addr_o  = addr_arr[winner];
            dev_we_o    = host_we_i[winner];
            dev_be_o    = be_arr[winner];
            dev_wdata_o = wdata_arr[winner];
        end
    end

    assign host_gnt_o    = push ? (NrHosts'(1) << winner) : '0;
    assign host_rvalid_o = pop ? (NrHosts'(1) << head_idx) : '0;
    assign host_rdata_o  = dev_rdata_i;
    assign host_err_o    = dev_err_i & pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q       <= '0;
            lock_idx_q     <= '0;
            lock_vld_q     <= 1'b0;
            spurious_rsp_o <= 1'b0;
        end else begin
            if (push) begin
                rr_ptr_q   <= (winner == IdxW'(NrHosts - 1)) ? '0 : winner + IdxW'(1);
                lock_vld_q <= 1'b0;
            end else if (dev_req_o) begin
                lock_vld_q <= 1'b1;
                lock_idx_q <= winner;
            end else if (!lock_hold) begin
                lock_vld_q <= 1'b0;
            end
            if (dev_rvalid_i & fifo_empty) spurious_rsp_o <= 1'b1;
        end
    end

    bus_host_arbiter_fifo #(
        .Width (IdxW),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (winner),
        .pop_i   (pop),
        .rdata_o (head_idx),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (outstanding_o)
    );
endmodule

// File: tb/tb_bus_host_arbiter.sv
// Bench for bus_host_arbiter: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_bus_host_arbiter;
    localparam int NH = 2, DW = 32, AW = 32, MAXO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NH-1:0]    req;
    logic [AW-1:0]    h_addr  [NH];
    logic [NH-1:0]    h_we;
    logic [3:0]       h_be    [NH];
    logic [DW-1:0]    h_wdata [NH];
    logic [NH*AW-1:0] addr_bus;
    logic [NH*4-1:0]  be_bus;
    logic [NH*DW-1:0] wdata_bus;
    logic             dgnt, drvalid, derr;
    logic [DW-1:0]    drdata;

    logic [NH-1:0]    gnt, rvalid;
    logic [DW-1:0]    rdata, dwdata;
    logic             err, dreq, dwe, spur;
    logic [AW-1:0]    daddr;
    logic [3:0]       dbe;
    logic [1:0]       outstanding;

    for (genvar g = 0; g < NH; g++) begin : g_pack
        assign addr_bus[g*AW +: AW]  = h_addr[g];
        assign be_bus[g*4 +: 4]      = h_be[g];
        assign wdata_bus[g*DW +: DW] = h_wdata[g];
    end

    bus_host_arbiter #(
        .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(req), .host_gnt_o(gnt), .host_addr_i(addr_bus), .host_we_i(h_we),
        .host_be_i(be_bus), .host_wdata_i(wdata_bus), .host_rvalid_o(rvalid),
        .host_rdata_o(rdata), .host_err_o(err),
        .dev_req_o(dreq), .dev_gnt_i(dgnt), .dev_addr_o(daddr), .dev_we_o(dwe),
        .dev_be_o(dbe), .dev_wdata_o(dwdata), .dev_rvalid_i(drvalid),
        .dev_rdata_i(drdata), .dev_err_i(derr),
        .outstanding_o(outstanding), .spurious_rsp_o(spur)
    );

    int n_vec = 0, n_err = 0;

    // Reference model: ordered list of hosts awaiting answers, next-priority host, held host (-1 none).
    int m_q[$];
    int m_ptr, m_lock;
    bit m_spur;
    int e_win;
    bit e_req, e_hs, e_pop;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ptr  = 0;
        m_lock = -1;
        m_spur = 0;
    endtask

    task automatic check_outputs();
        bit found;
        int h;
        logic [NH-1:0] e_gnt, e_rv;
        e_req = (|req) && (m_q.size() < MAXO) && !rst;
        found = 0;
        e_win = 0;
        if (m_lock >= 0 && req[m_lock]) begin
            e_win = m_lock;
            found = 1;
        end
        for (int i = 0; i < NH; i++) begin
            h = (m_ptr + i) % NH;
            if (!found && req[h]) begin
                e_win = h;
                found = 1;
            end
        end
        e_hs  = e_req && dgnt;
        e_pop = drvalid && (m_q.size() > 0) && !rst;
        e_gnt = e_hs ? (NH'(1) << e_win) : '0;
        e_rv  = e_pop ? (NH'(1) << m_q[0]) : '0;
        chk("host_gnt", gnt, e_gnt);
        chk("host_rvalid", rvalid, e_rv);
        chk("dev_req", dreq, e_req);
        chk("dev_addr", daddr, e_req ? h_addr[e_win] : '0);
        chk("dev_we", dwe, e_req ? h_we[e_win] : 1'b0);
        chk("dev_be", dbe, e_req ? h_be[e_win] : 4'h0);
        chk("dev_wdata", dwdata, e_req ? h_wdata[e_win] : '0);
        if (e_pop) begin
            chk("host_rdata", rdata, drdata);
            chk("host_err", err, derr);
        end
        chk("outstanding", outstanding, m_q.size());
        chk("spurious", spur, m_spur);
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            if (drvalid && m_q.size() == 0) m_spur = 1;
            if (e_pop) void'(m_q.pop_front());
            if (e_hs) begin
                m_q.push_back(e_win);
                m_ptr  = (e_win + 1) % NH;
                m_lock = -1;
            end else if (e_req) begin
                m_lock = e_win;
            end else if (m_lock >= 0 && !req[m_lock]) begin
                m_lock = -1;
            end
        end
        #1;
    endtask

    task automatic eval();
        #1;
        check_outputs();
    endtask

    task automatic cyc();
        eval();
        advance();
    endtask

    task automatic set_idle();
        req = '0; h_we = '0; dgnt = 0; drvalid = 0; derr = 0; drdata = '0;
        for (int h = 0; h < NH; h++) begin
            h_addr[h] = '0; h_be[h] = '0; h_wdata[h] = '0;
        end
    endtask

    task automatic rand_inputs();
        for (int h = 0; h < NH; h++) begin
            req[h]     = ($urandom_range(0, 9) < 7);
            h_addr[h]  = $urandom;
            h_we[h]    = 1'($urandom_range(0, 1));
            h_be[h]    = 4'($urandom);
            h_wdata[h] = $urandom;
        end
        dgnt    = 1'($urandom_range(0, 1));
        drvalid = (m_q.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 2);
        drdata  = $urandom;
        derr    = 1'($urandom_range(0, 1));
    endtask

    // Asserts reset with whatever inputs are currently driven, checks outputs while held, releases.
    task automatic apply_reset();
        rst = 1;
        model_reset();
        #1;
        check_outputs();
        chk("rst_gnt", gnt, '0);
        chk("rst_rvalid", rvalid, '0);
        chk("rst_dev_req", dreq, 1'b0);
        chk("rst_outstanding", outstanding, 2'd0);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        set_idle();
        model_reset();
        apply_reset();

        // Reset in the middle of traffic with requests, grant and response all high.
        req = 2'b01; dgnt = 1;
        cyc();
        req = 2'b11; drvalid = 1; drdata = 32'h1234;
        apply_reset();
        set_idle();

        // Fairness: both hosts request every cycle, device answers one cycle after each grant.
        req = 2'b11; dgnt = 1;
        h_addr[0] = 32'h1000; h_addr[1] = 32'h2000;
        for (int k = 0; k < 8; k++) begin
            drvalid = (k > 0);
            drdata  = 32'(k);
            eval();
            chk("fair_gnt", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) chk("fair_rvalid", rvalid, (k % 2 == 1) ? 2'b01 : 2'b10);
            advance();
        end

        // Lock: move priority to host1, then stall host0 while host1 also requests.
        set_idle();
        apply_reset();
        h_addr[0] = 32'h0010_0000; h_addr[1] = 32'h0000_0200;
        req = 2'b01; dgnt = 1;
        cyc();
        req = 2'b00; dgnt = 0; drvalid = 1;
        cyc();
        drvalid = 0; req = 2'b01;
        eval();
        chk("lock_addr0", daddr, 32'h0010_0000);
        advance();
        req = 2'b11;
        for (int k = 0; k < 2; k++) begin
            eval();
            chk("lock_addr", daddr, 32'h0010_0000);
            chk("lock_nogrant", gnt, 2'b00);
            advance();
        end
        dgnt = 1;
        eval();
        chk("lock_first_gnt", gnt, 2'b01);
        advance();
        eval();
        chk("lock_second_gnt", gnt, 2'b10);
        advance();

        // Full: two grants without answers block the request, even on the cycle a response arrives.
        set_idle();
        apply_reset();
        req = 2'b01; dgnt = 1;
        cyc();
        cyc();
        eval();
        chk("full_dev_req", dreq, 1'b0);
        chk("full_outstanding", outstanding, 2'd2);
        advance();
        drvalid = 1;
        eval();
        chk("full_nobypass", dreq, 1'b0);
        chk("full_rvalid", rvalid, 2'b01);
        advance();
        drvalid = 0;
        eval();
        chk("full_reopen", dreq, 1'b1);
        chk("full_outstanding1", outstanding, 2'd1);
        advance();

        // Routing: host1 read answered with data and error.
        set_idle();
        apply_reset();
        req = 2'b10; dgnt = 1;
        cyc();
        req = 2'b00; dgnt = 0; drvalid = 1; drdata = 32'hDEAD_BEEF; derr = 1;
        eval();
        chk("route_rvalid", rvalid, 2'b10);
        chk("route_rdata", rdata, 32'hDEAD_BEEF);
        chk("route_err", err, 1'b1);
        advance();

        // Spurious response with nothing outstanding; flag stays until reset.
        set_idle();
        apply_reset();
        drvalid = 1;
        eval();
        chk("spur_rvalid", rvalid, 2'b00);
        chk("spur_before", spur, 1'b0);
        advance();
        drvalid = 0;
        for (int k = 0; k < 3; k++) begin
            eval();
            chk("spur_sticky", spur, 1'b1);
            advance();
        end
        apply_reset();
        chk("spur_cleared", spur, 1'b0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            if ($urandom_range(0, 399) == 0) begin
                apply_reset();
            end else begin
                cyc();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
